// File: rtl/pianotile_pkg.sv
// Shared types and constants for the scrolling-tile game controller:
// game state encoding, lane count, pattern decode constants and the
// LFSR tap mask with its next-state helper.
package pianotile_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_t;

    localparam int LANES = 3;

    // Pattern decode: an LFSR whose top two bits are both set yields an
    // empty column; otherwise the low two bits (mod 3) pick the lane.
    localparam logic [LANES-1:0] PAT_NONE      = 3'b000;
    localparam logic [1:0]       PAT_BLANK_SEL = 2'b11;
    localparam logic [LANES-1:0] PAT_LANE0     = 3'b001;
    localparam logic [LANES-1:0] PAT_LANE1     = 3'b010;
    localparam logic [LANES-1:0] PAT_LANE2     = 3'b100;

    // Taps 8,6,5,4 of the 8-bit Fibonacci LFSR (bits 7,5,4,3).
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    localparam logic [1:0] LIVES_INIT = 2'd3;

    // Shift left; XOR of the tapped bits feeds bit 0.
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/tile_lfsr.sv
// 8-bit Fibonacci LFSR used as the tile pattern source. Loads SEED on
// reset and advances one step whenever advance is high. Only the raw
// state is exported; pattern decoding lives in the sequencer.
module tile_lfsr
    import pianotile_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       advance,
    output logic [7:0] value
);

    // Seed on reset, step on each scroll tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= SEED;
        end else if (advance) begin
            value <= lfsr_next(value);
        end
    end

endmodule

// File: rtl/tile_sequencer.sv
// Game controller for the 3-lane scrolling tile display: scroll timing,
// tile generation, hit-line judgment, scoring and the IDLE/PLAY/OVER FSM.
// Optional feature macro: LIVES_EN (adds a 2-bit lives counter and the
// lives output; a miss only ends the game when the last life is lost).
//
// Display strobe: shift_en is high for exactly one cycle per scroll step
// and data carries the newest column in that same cycle; the driver has
// no back-pressure, so there is no ready. data holds between strobes.
module tile_sequencer
    import pianotile_pkg::*;
#(
    parameter int         TICK_DIV = 2500000,
    parameter int         DEPTH    = 16,
    parameter int         LVL_PTS  = 16,
    parameter logic [7:0] SEED     = 8'hA5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LANES-1:0] key,
    output logic [LANES-1:0] data,
    output logic             shift_en,
    output logic [7:0]       score,
    output logic [1:0]       level,
    output logic             playing,
    output logic             game_over
`ifdef LIVES_EN
    ,
    output logic [1:0]       lives
`endif
);

    localparam int CW = $clog2(TICK_DIV + 1);

    state_t           state;
    logic [LANES-1:0] col [DEPTH];
    logic             hit;
    logic [CW-1:0]    cnt;
    logic [7:0]       lfsr_val;

    logic [LANES-1:0] head;
    logic [LANES-1:0] pat;
    logic             tick;
    logic             pending;
    logic             key_hit;
    logic             key_miss;
    logic             resolved;
    logic             tick_miss;
    logic             miss;
    logic             game_end;
    logic             do_shift;

    // Terminal count for a level; deep levels never drop below one cycle.
    function automatic logic [CW-1:0] term_of(input logic [1:0] lv);
        int p;
        p = TICK_DIV >> lv;
        if (p < 1) p = 1;
        return CW'(p - 1);
    endfunction

    // Speed level from score, capped at 3.
    function automatic logic [1:0] level_of(input logic [7:0] s);
        int q;
        q = int'(s) / LVL_PTS;
        return (q > 3) ? 2'd3 : 2'(q);
    endfunction

    // Column pattern from an LFSR value.
    function automatic logic [LANES-1:0] decode_pattern(input logic [7:0] s);
        logic [LANES-1:0] p;
        p = PAT_NONE;
        if (s[7:6] != PAT_BLANK_SEL) begin
            case (s[1:0])
                2'd1:    p = PAT_LANE1;
                2'd2:    p = PAT_LANE2;
                default: p = PAT_LANE0;
            endcase
        end
        return p;
    endfunction

    tile_lfsr #(.SEED(SEED)) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .advance (do_shift),
        .value   (lfsr_val)
    );

    // Hit-line judgment: key is judged first, then the tick sees the
    // updated flag. A wrong key also marks the tile resolved so the same
    // tile cannot cost a second miss at its tick.
    always_comb begin
        head      = col[0];
        tick      = (state == PLAY) && (cnt >= term_of(level));
        pending   = (state == PLAY) && (head != PAT_NONE) && !hit;
        key_hit   = pending && (key == head);
        key_miss  = pending && (key != head) && (key != PAT_NONE);
        resolved  = hit | key_hit | key_miss;
        tick_miss = tick && (head != PAT_NONE) && !resolved;
        miss      = key_miss | tick_miss;
`ifdef LIVES_EN
        game_end  = miss && (lives == 2'd1);
`else
        game_end  = miss;
`endif
        do_shift  = tick && !game_end;
        pat       = decode_pattern(lfsr_next(lfsr_val));
    end

    assign playing   = (state == PLAY);
    assign game_over = (state == OVER);

    // Game FSM with scroll timing, column queue, score and level.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            data     <= PAT_NONE;
            shift_en <= 1'b0;
            score    <= 8'd0;
            level    <= 2'd0;
            hit      <= 1'b0;
            cnt      <= '0;
            for (int i = 0; i < DEPTH; i++) col[i] <= PAT_NONE;
`ifdef LIVES_EN
            lives    <= LIVES_INIT;
`endif
        end else begin
            shift_en <= 1'b0;
            case (state)
                IDLE, OVER: begin
                    if (start) begin
                        state <= PLAY;
                        data  <= PAT_NONE;
                        score <= 8'd0;
                        level <= 2'd0;
                        hit   <= 1'b0;
                        cnt   <= '0;
                        for (int i = 0; i < DEPTH; i++) col[i] <= PAT_NONE;
`ifdef LIVES_EN
                        lives <= LIVES_INIT;
`endif
                    end
                end
                PLAY: begin
                    level <= level_of(score);
                    if (game_end) begin
                        state <= OVER;
                    end else begin
                        if (key_hit && (score != 8'hFF)) score <= score + 8'd1;
`ifdef LIVES_EN
                        if (miss) lives <= lives - 2'd1;
`endif
                        if (do_shift) begin
                            for (int i = 0; i < DEPTH - 1; i++) col[i] <= col[i+1];
                            col[DEPTH-1] <= pat;
                            data         <= pat;
                            shift_en     <= 1'b1;
                            hit          <= 1'b0;
                            cnt          <= '0;
                        end else begin
                            hit <= resolved;
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tile_sequencer.sv
// Self-checking bench for tile_sequencer. A behavioural game model built
// from the game rules (queue of columns, LFSR by tap positions) predicts
// each scroll strobe into exp_q; a separate monitor pops and compares on
// every shift_en. Score/level/state outputs are compared every cycle.
module tb_tile_sequencer;

    localparam int         TICK_DIV = 4;
    localparam int         DEPTH    = 16;
    localparam int         LVL_PTS  = 16;
    localparam logic [7:0] SEED     = 8'hA5;
    localparam int         W        = 19;   // {cycle tag[15:0], data[2:0]}
`ifdef LIVES_EN
    localparam bit LIVES = 1'b1;
`else
    localparam bit LIVES = 1'b0;
`endif

    // Clock / reset and DUT signals
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] key;
    logic [2:0] data;
    logic       shift_en;
    logic [7:0] score;
    logic [1:0] level;
    logic       playing;
    logic       game_over;
`ifdef LIVES_EN
    logic [1:0] lives;
`endif

    always #5 clk = ~clk;

    tile_sequencer #(
        .TICK_DIV (TICK_DIV),
        .DEPTH    (DEPTH),
        .LVL_PTS  (LVL_PTS),
        .SEED     (SEED)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key       (key),
        .data      (data),
        .shift_en  (shift_en),
        .score     (score),
        .level     (level),
        .playing   (playing),
        .game_over (game_over)
`ifdef LIVES_EN
        ,
        .lives     (lives)
`endif
    );

    // Scoreboard and counters
    logic [W-1:0] exp_q[$];
    int           cyc;
    int           errors;
    int           checks;

    // Reference model state: 0 idle, 1 play, 2 over
    int         m_state;
    logic [2:0] m_cols[$];
    bit         m_hit;
    int         m_score;
    int         m_level;
    int         m_cnt;
    int         m_lives;
    logic [7:0] m_lfsr;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int period_now();
        int p;
        p = TICK_DIV >> m_level;
        return (p < 1) ? 1 : p;
    endfunction

    function automatic logic [2:0] pattern_from(input logic [7:0] s);
        logic [1:0] low;
        low = s[1:0];
        if (s[7] && s[6]) return 3'b000;
        return 3'(1 << (int'(low) % 3));
    endfunction

    task automatic clear_board();
        m_cols.delete();
        for (int i = 0; i < DEPTH; i++) m_cols.push_back(3'b000);
        m_hit   = 1'b0;
        m_score = 0;
        m_level = 0;
        m_cnt   = 0;
        m_lives = 3;
    endtask

    task automatic model_reset();
        clear_board();
        m_state = 0;
        m_lfsr  = SEED;
    endtask

    // Lose a life if one is spare (tile becomes resolved), else game over.
    function automatic bit take_miss();
        if (LIVES && m_lives > 1) begin
            m_lives--;
            m_hit = 1'b1;
            return 1'b0;
        end
        m_state = 2;
        return 1'b1;
    endfunction

    // Advance the model across one clock edge with the given inputs.
    task automatic model_step(input bit r, input bit st, input logic [2:0] k, input int tag);
        int         period;
        bit         tick;
        int         nlvl;
        logic [2:0] head;
        logic [2:0] p;
        logic       fb;
        if (r) begin
            model_reset();
            return;
        end
        if (m_state != 1) begin
            if (st) begin
                clear_board();
                m_state = 1;
            end
            return;
        end
        period = period_now();
        tick   = (m_cnt >= period - 1);
        nlvl   = m_score / LVL_PTS;
        if (nlvl > 3) nlvl = 3;
        m_level = nlvl;
        head   = m_cols[0];
        if (head != 3'b000 && !m_hit && k != 3'b000) begin
            if (k == head) begin
                m_hit = 1'b1;
                if (m_score < 255) m_score++;
            end else if (take_miss()) begin
                return;
            end
        end
        if (!tick) begin
            m_cnt++;
            return;
        end
        if (head != 3'b000 && !m_hit) begin
            if (take_miss()) return;
        end
        fb     = m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3];
        m_lfsr = {m_lfsr[6:0], fb};
        p      = pattern_from(m_lfsr);
        void'(m_cols.pop_front());
        m_cols.push_back(p);
        m_hit = 1'b0;
        m_cnt = 0;
        exp_q.push_back({tag[15:0], p});
    endtask

    task automatic check_status();
        check("score", int'(score), m_score);
        check("level", int'(level), m_level);
        check("playing", int'(playing), int'(m_state == 1));
        check("game_over", int'(game_over), int'(m_state == 2));
`ifdef LIVES_EN
        check("lives", int'(lives), m_lives);
`endif
    endtask

    // Driver: apply inputs just after an edge, predict, wait one edge, check.
    task automatic step(input bit r, input bit st, input logic [2:0] k);
        rst   = r;
        start = st;
        key   = k;
        model_step(r, st, k, cyc + 1);
        @(posedge clk);
        cyc++;
        #1;
        check_status();
    endtask

    // Correct key for the pending tile (forced on a tick cycle), plus the
    // occasional duplicate press after the tile was already hit.
    function automatic logic [2:0] pick_correct();
        logic [2:0] h;
        if (m_state != 1) return 3'b000;
        h = m_cols[0];
        if (h == 3'b000) return 3'b000;
        if (!m_hit) begin
            if (m_cnt >= period_now() - 1 || $urandom_range(0, 1) == 1) return h;
            return 3'b000;
        end
        if ($urandom_range(0, 7) == 0) return h;
        return 3'b000;
    endfunction

    function automatic logic [2:0] wrong_key(input logic [2:0] h);
        logic [2:0] k;
        k = 3'($urandom_range(1, 7));
        while (k == h) k = 3'($urandom_range(1, 7));
        return k;
    endfunction

    // Monitor: compares every scroll strobe against the expected queue.
    task automatic monitor_loop();
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0][W-1:3] < cyc[15:0]) begin
                checks++;
                errors++;
                $display("FAIL shift_missing: got no shift_en expected data=%b at cycle %0d",
                         exp_q[0][2:0], exp_q[0][W-1:3]);
                void'(exp_q.pop_front());
            end
            if (shift_en) begin
                if (exp_q.size() > 0 && exp_q[0][W-1:3] == cyc[15:0]) begin
                    check("shift_data", int'(data), int'(exp_q[0][2:0]));
                    void'(exp_q.pop_front());
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL shift_unexpected: got shift_en=1 data=%b expected no shift (cycle %0d)",
                             data, cyc);
                end
            end
        end
    endtask

    initial begin
        int         n;
        bit         r;
        bit         s;
        int         sel;
        logic [2:0] k;
        errors = 0;
        checks = 0;
        cyc    = 0;
        rst    = 1'b1;
        start  = 1'b0;
        key    = 3'b000;
        model_reset();
        fork
            monitor_loop();
        join_none

        // Reset held two cycles, then idle with no start
        step(1'b1, 1'b0, 3'b000);
        step(1'b1, 1'b0, 3'b000);
        repeat (3 * TICK_DIV) step(1'b0, 1'b0, 3'b000);
        // Reset wins over a simultaneous start
        step(1'b1, 1'b1, 3'b000);

        // Game with no keys: first unhit tile ends it with score 0
        step(1'b0, 1'b1, 3'b000);
        n = 0;
        while (m_state == 1 && n < 600) begin
            step(1'b0, 1'b0, 3'b000);
            n++;
        end
        check("no_key_game_over", int'(game_over), 1);
        check("no_key_score", int'(score), 0);

        // Correct keys through the level changes
        step(1'b0, 1'b1, 3'b000);
        n = 0;
        while (m_state == 1 && m_score < 50 && n < 3000) begin
            step(1'b0, 1'b0, pick_correct());
            n++;
        end
        check("hit_run_playing", int'(playing), 1);
        check("hit_run_score", int'(score), 50);
        check("hit_run_level", int'(level), 3);

        // Wrong lane on every pending tile until the game ends
        n = 0;
        while (m_state == 1 && n < 2000) begin
            k = pick_correct();
            if (m_cols[0] != 3'b000 && !m_hit) k = wrong_key(m_cols[0]);
            step(1'b0, 1'b0, k);
            n++;
        end
        check("wrong_key_over", int'(game_over), 1);

        // Outputs frozen in OVER whatever the keys do
        repeat (8) step(1'b0, 1'b0, 3'($urandom_range(0, 7)));

        // Restart, ignored start in PLAY, then reset mid-game
        step(1'b0, 1'b1, 3'b000);
        repeat (5) step(1'b0, 1'b0, 3'b000);
        step(1'b0, 1'b1, 3'b000);
        repeat (40) step(1'b0, 1'b0, pick_correct());
        step(1'b1, 1'b0, 3'b000);
        check("rst_mid_game_idle", int'(playing), 0);
        step(1'b0, 1'b0, 3'b000);

        // Random play
        for (int i = 0; i < 2500; i++) begin
            r   = ($urandom_range(0, 299) == 0);
            s   = ($urandom_range(0, 19) == 0);
            sel = int'($urandom_range(0, 9));
            if (sel < 6)       k = pick_correct();
            else if (sel == 6) k = 3'($urandom_range(0, 7));
            else               k = 3'b000;
            step(r, s, k);
        end

        step(1'b0, 1'b0, 3'b000);
        @(negedge clk);
        #1;
        check("exp_q_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tile_sequencer.md
Name: tile_sequencer

Overview:
Game controller for the 3-lane scrolling tile display. It generates the lane pattern for each scroll step and issues the scroll strobe to the dot-matrix driver. It tracks the tiles in flight, judges player key presses against the tile at the hit line, keeps score and runs the IDLE/PLAY/OVER game state machine. It sits between the debounced key inputs and the dot-matrix display driver.

Parameters:
TICK_DIV, 2500000, clk cycles per scroll step at speed level 0
DEPTH, 16, number of columns tracked (matches display width)
LVL_PTS, 16, points per speed level increase
SEED, 8'hA5, LFSR reset seed (must be nonzero)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a game from IDLE or OVER
key  in  3  one-cycle debounced press pulses, bit n = lane n
data  out  3  lane pattern for newest column (one-hot or 000)
shift_en  out  1  one-cycle scroll strobe; data valid in same cycle
score  out  8  hits this game, saturates at 255
level  out  2  current speed level 0..3
playing  out  1  high in PLAY
game_over  out  1  high in OVER

Behaviour:
- One clock; reset is synchronous and active-high (rst sampled on posedge clk).
- Reset: state=IDLE, data=000, shift_en=0, score=0, level=0, playing=0, game_over=0, all DEPTH columns=000, hit flag=0, tick counter=0, LFSR=SEED.
- FSM:
  - IDLE: start -> PLAY. On entry to PLAY, clear columns, score, level, hit flag and tick counter. The LFSR is not reseeded, so each game gets a new sequence.
  - PLAY: a miss -> OVER.
  - OVER: outputs frozen (score held), no shift_en; start -> PLAY with the same clears.
  - rst overrides everything, including a start in the same cycle.
- Tick: in PLAY, the counter counts 0..(TICK_DIV>>level)-1. At terminal count it wraps to 0 and a tick occurs.
- On a tick:
  - LFSR advances: 8-bit Fibonacci, taps 8,6,5,4, shift left, feedback into bit 0.
  - New pattern p comes from the updated LFSR. If lfsr[7:6]==11, p=000. Otherwise p = one-hot of (lfsr[1:0] mod 3).
  - The column queue shifts: col[DEPTH-1] <= p, col[i] <= col[i+1], and col[0] leaves.
  - data<=p and shift_en=1 for exactly one cycle. data holds its value between ticks.
- Hit line is col[0] (the oldest column).
- Key judgment, every PLAY cycle, using pre-tick col[0]:
  - col[0]==000 or hit flag set: keys ignored.
  - Otherwise, key==col[0] exactly: score+1 (saturating) and hit flag set.
  - Otherwise, any nonzero key: miss.
- Tick miss check: col[0]!=000 and hit flag (including a hit earned this same cycle) clear -> miss. After any tick the hit flag clears.
- Simultaneous key and tick: the key is judged first; the tick then evaluates the updated flag and shifts.
- Level = min(3, score / LVL_PTS), updated the cycle after score changes. A new period takes effect at the next counter wrap. If the counter is already at or past the new terminal count, the tick fires next cycle.
- Miss takes effect next cycle: playing=0, game_over=1. No further shift_en. The score does not include the missed tile.
- start while in PLAY is ignored.

Optional Feature:
LIVES_EN.
- Defined: a 2-bit lives counter, reset/game start value 3. A miss decrements it, and the affected tile counts as resolved (hit flag set). Entering OVER happens only when a miss occurs with lives==1. Adds output lives[1:0].
- Undefined: the first miss goes to OVER; no lives port.

Decomposition:
- Package pianotile_pkg: state enum (IDLE, PLAY, OVER), LANES=3, pattern decode constants, LFSR tap mask.
- Sub-module tile_lfsr:
  - 8-bit LFSR with synchronous load of SEED on rst and an advance enable.
  - Outputs the raw state; pattern decode stays in tile_sequencer.

Test Plan:
- rst held 2 cycles, then released, no start -> all outputs 0, no shift_en for 3*TICK_DIV cycles.
- TICK_DIV=4, start, no keys -> shift_en every 4 cycles, data matches the LFSR model from seed A5. The first nonzero pattern reaching col[0] is unhit at the next tick, so game_over=1 the cycle after, with score=0.
- Model-driven correct key pulse for each pending col[0] over 40 ticks, LVL_PTS=16 -> score=count of nonzero columns. The period shrinks from 4 to 2 at score 16 and from 2 to 1 at score 32. No game_over.
- Wrong lane (col[0]=010, key=001) -> miss; key=011 with col[0]=010 -> miss. A duplicate correct press after a hit -> ignored, score unchanged.
- Correct key in the same cycle as a tick -> counted as a hit, no miss, shift proceeds.
- LIVES_EN: three misses -> lives 3,2,1 then OVER on the third. A start from OVER -> score=0, lives=3, PLAY. rst mid-game -> IDLE next cycle.
